// File: rtl/game_pkg.sv
// game_pkg: shared widths, FSM encoding and LFSR taps for the mole game blocks
package game_pkg;
    localparam int NUM_LEDS  = 18;
    localparam int LED_IDX_W = 5;
    localparam int SCORE_W   = 12;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, PICK = 2'd2} state_t;
endpackage

// File: rtl/mole_spawner_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    // Shift every cycle; feedback is the parity of the tapped bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= SEED;
        else     q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/mole_spawner.sv
// mole_spawner: paces mole spawns by difficulty level and picks a random dark LED
module mole_spawner
    import game_pkg::*;
#(
    parameter int          CLK_HZ            = 50_000_000,
    parameter int          START_INTERVAL_MS = 1500,
    parameter int          STEP_MS           = 100,
    parameter int          MIN_INTERVAL_MS   = 400,
    parameter int          HITS_PER_LEVEL    = 5,
    parameter int          MAX_LEVEL         = 15,
    parameter int          RETRY_LIMIT       = 32,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_LEDS-1:0]  leds,
    input  logic [SCORE_W-1:0]   score,
    output logic                 led_request,
    output logic [LED_IDX_W-1:0] led_index,
    output logic [3:0]           level,
    output logic [15:0]          spawn_count
);
    localparam int TICK  = CLK_HZ / 1000;
    localparam int PRE_W = TICK > 1 ? $clog2(TICK) : 1;
    localparam int RTY_W = $clog2(RETRY_LIMIT + 1);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_PICK = PICK;

    logic [15:0]          lfsr;
    logic                 unused_lfsr;
    logic [1:0]           state;
    logic [PRE_W-1:0]     pre;
    logic [15:0]          wait_cnt;
    logic [15:0]          interval;
    logic [RTY_W-1:0]     retry;
    logic [LED_IDX_W-1:0] cand;
    logic [31:0]          leds_ext;
    logic signed [31:0]   span;
    logic                 tick;
    logic                 valid;
    logic                 give_up;
    logic                 level_up;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

    assign unused_lfsr = ^lfsr[15:LED_IDX_W];

    // Candidate qualification, ms tick, level step and the clamped (never wrapping) interval
    always_comb begin
        cand     = lfsr[LED_IDX_W-1:0];
        leds_ext = 32'(leds);
        valid    = (cand < LED_IDX_W'(NUM_LEDS)) && !leds_ext[cand];
        tick     = pre == PRE_W'(TICK - 1);
        give_up  = retry == RTY_W'(RETRY_LIMIT - 1);
        level_up = (32'(score) >= (32'(level) + 32'd1) * 32'(HITS_PER_LEVEL)) && (level < 4'(MAX_LEVEL));
        span     = START_INTERVAL_MS - $signed(32'(level)) * STEP_MS;
        interval = span < MIN_INTERVAL_MS ? 16'(MIN_INTERVAL_MS) : 16'(span);
    end

    // Spawn FSM: timed WAIT, retrying PICK, one-cycle request pulse; enable low parks in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pre         <= '0;
            wait_cnt    <= '0;
            retry       <= '0;
            led_request <= 1'b0;
            led_index   <= '0;
            level       <= '0;
            spawn_count <= '0;
        end else begin
            led_request <= 1'b0;
            if (level_up) level <= level + 4'd1;
            if (!enable) begin
                state    <= S_IDLE;
                pre      <= '0;
                wait_cnt <= '0;
                retry    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state    <= S_WAIT;
                        pre      <= '0;
                        wait_cnt <= interval;
                    end
                    S_WAIT: begin
                        pre <= tick ? '0 : pre + 1'b1;
                        if (tick) begin
                            wait_cnt <= wait_cnt - 16'd1;
                            if (wait_cnt == 16'd1) state <= S_PICK;
                        end
                    end
                    S_PICK: begin
                        if (valid || give_up) begin
                            state    <= S_WAIT;
                            pre      <= '0;
                            wait_cnt <= interval;
                            retry    <= '0;
                        end else begin
                            retry <= retry + 1'b1;
                        end
                        if (valid) begin
                            led_request <= 1'b1;
                            led_index   <= cand;
                            spawn_count <= spawn_count + {15'd0, spawn_count != 16'hFFFF};
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: directed/randomized checks of mole_spawner against a spawn-schedule model
module tb_mole_spawner;
    import game_pkg::*;

    localparam int START = 10;
    localparam int STEP  = 2;
    localparam int MINI  = 4;
    localparam int HITS  = 3;
    localparam int TPM   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [17:0] leds = '0;
    logic [11:0] score = '0;
    logic        led_request;
    logic [4:0]  led_index;
    logic [3:0]  level;
    logic [15:0] spawn_count;

    int total = 0;
    int bad = 0;

    logic [15:0] m;
    int          cyc, lvl, ent_lvl, ent_cyc, nxt;
    logic [15:0] spawns;
    logic        active, entered, exp_req, pl_req;
    logic [4:0]  pl_idx, e_idx;

    mole_spawner #(
        .CLK_HZ(4000), .START_INTERVAL_MS(START), .STEP_MS(STEP), .MIN_INTERVAL_MS(MINI),
        .HITS_PER_LEVEL(HITS), .MAX_LEVEL(15), .RETRY_LIMIT(32), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .leds(leds), .score(score),
        .led_request(led_request), .led_index(led_index), .level(level), .spawn_count(spawn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nx(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Predict the next WAIT exit from the entry point: interval in ticks, then up to 32 candidates
    task automatic plan();
        int iv, d;
        logic [15:0] mm;
        iv = START - STEP * ent_lvl;
        if (iv < MINI) iv = MINI;
        ent_cyc = cyc;
        mm = m;
        repeat (TPM * iv) mm = nx(mm);
        pl_req = 1'b0;
        d = TPM * iv + 32;
        for (int k = 0; k < 32; k++) begin
            if (!pl_req && mm[4:0] < 5'd18 && !leds[mm[4:0]]) begin
                pl_req = 1'b1;
                pl_idx = mm[4:0];
                d = TPM * iv + k + 1;
            end
            mm = nx(mm);
        end
        nxt = cyc + d;
    endtask

    task automatic model_reset();
        m = 16'hACE1; cyc = 0; lvl = 0; spawns = '0; active = 1'b0; entered = 1'b0; exp_req = 1'b0;
    endtask

    task automatic step();
        int old;
        @(posedge clk);
        old = lvl;
        if (int'(score) >= (lvl + 1) * HITS && lvl < 15) lvl++;
        m = nx(m);
        cyc++;
        exp_req = 1'b0;
        entered = 1'b0;
        if (!enable) active = 1'b0;
        else if (!active) begin
            active = 1'b1; ent_lvl = old; plan(); entered = 1'b1;
        end else if (cyc == nxt) begin
            exp_req = pl_req;
            e_idx = pl_idx;
            if (pl_req && spawns != 16'hFFFF) spawns++;
            ent_lvl = old; plan(); entered = 1'b1;
        end
        #1;
        chk("req", led_request, exp_req);
        if (exp_req) chk("idx", led_index, e_idx);
        chk("cnt", spawn_count, spawns);
        chk("lvl", level, lvl);
        chk("lfsr", dut.u_lfsr.q, m);
    endtask

    task automatic run_until_entry(input int budget, input string tag);
        int i;
        i = 0;
        do begin step(); i++; end while (!entered && i < budget);
        total++;
        assert (entered) else begin
            bad++;
            $error("FAIL %s observed=timeout expected=wait_entry", tag);
        end
    endtask

    initial begin
        int t, n;
        logic [15:0] mm, s0;
        logic [17:0] lit;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", led_request, 0);
        chk("rst_idx", led_index, 0);
        chk("rst_lvl", level, 0);
        chk("rst_cnt", spawn_count, 0);
        chk("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
        chk("rst_state", dut.state, IDLE);
        rst = 1'b0;
        repeat (3) step();

        enable = 1'b1;
        run_until_entry(2, "t1_entry");
        t = cyc;
        run_until_entry(200, "t1_spawn");
        if (exp_req) begin
            chk("t1_spawns", spawn_count, 1);
            chk("t1_min_lat", (cyc - t) >= 41, 1);
        end

        for (int r = 0; r < 3; r++) begin
            mm = m;
            repeat (TPM * START) mm = nx(mm);
            lit = '0;
            n = 0;
            for (int k = 0; k < 32 && n < 2; k++) begin
                if (mm[4:0] < 5'd18) begin lit[mm[4:0]] = 1'b1; n++; end
                mm = nx(mm);
            end
            leds = lit | 18'($urandom & $urandom & $urandom);
            plan();
            t = cyc;
            run_until_entry(200, "t2_spawn");
            if (exp_req) begin
                chk("t2_range", led_index < 5'd18, 1);
                chk("t2_dark", (32'(leds) >> led_index) & 32'd1, 0);
                chk("t2_delayed", (cyc - t) >= 42, 1);
            end
        end
        leds = '0;
        plan();

        repeat (20) step();
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        run_until_entry(2, "t5_entry");
        t = cyc;
        run_until_entry(200, "t5_spawn");
        chk("t5_full_wait", (cyc - t) >= 41, 1);
        chk("t5_lvl_kept", level, 0);

        score = 12'd7;
        step();
        chk("t3_lvl1", level, 1);
        step();
        chk("t3_lvl2", level, 2);
        run_until_entry(200, "t3_old_int");
        t = cyc;
        run_until_entry(200, "t3_int6");
        chk("t3_int6_len", (cyc - t) >= 25 && (cyc - t) < 57, 1);
        score = 12'd30;
        run_until_entry(200, "t3_ramp");
        chk("t3_lvl10", level, 10);
        t = cyc;
        run_until_entry(200, "t3_int4");
        chk("t3_int4_len", (cyc - t) >= 17 && (cyc - t) < 49, 1);

        leds = 18'h3FFFF;
        plan();
        s0 = spawns;
        t = cyc;
        run_until_entry(200, "t4_giveup");
        chk("t4_len", cyc - t, TPM * MINI + 32);
        chk("t4_cnt", spawn_count, s0);

        repeat (TPM * MINI + 3) step();
        #3 rst = 1'b1;
        #1;
        chk("t6_req", led_request, 0);
        chk("t6_idx", led_index, 0);
        chk("t6_lvl", level, 0);
        chk("t6_cnt", spawn_count, 0);
        chk("t6_lfsr", dut.u_lfsr.q, 16'hACE1);
        chk("t6_state", dut.state, IDLE);
        leds = '0;
        score = '0;
        #1 rst = 1'b0;
        model_reset();
        run_until_entry(2, "t6_entry");
        run_until_entry(200, "t6_spawn");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
